ysyx_041514_pipe_ctrl: RTL and testbench
========================================

# ysyx_041514_pipe_ctrl

Central pipeline controller for the 6-stage core (PC, IF, ID, EX, MEM, WB). It merges per-stage stall requests into the `stall_valid`/`flush_valid` buses consumed by every pipeline register, including the PC register. It arbitrates PC redirects from EX (branch), MEM (trap) and MEM (fence.i), holding a redirect in a register while the PC stage is stalled. It also sequences fence.i through an icache-flush handshake.

## Interface
- `XLEN`, 64, data/PC width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous reset, active-low (0 = reset)
- `if_stall_req_i`  in  1  icache fetch not complete
- `ex_stall_req_i`  in  1  EX busy (mul/div, load-use)
- `mem_stall_req_i`  in  1  dcache/MMIO busy
- `branch_req_i`, `branch_pc_i`  in  1, XLEN  EX branch/jump mispredict and target
- `trap_req_i`, `trap_pc_i`  in  1, XLEN  MEM trap/mret and target
- `fencei_req_i`, `fencei_pc_i`  in  1, XLEN  fence.i in MEM and its own PC
- `icache_flush_done_i`  in  1  icache invalidate finished, 1-cycle pulse
- `icache_flush_req_o`  out  1  level; held until done
- `stall_valid_o`  out  6  stall per stage, bit0=PC … bit5=WB
- `flush_valid_o`  out  6  bubble per stage; bit0 is always 0
- `redirect_pc_o`  out  XLEN  target to PC register
- `branch_pc_valid_o`, `clint_pc_valid_o`, `clint_pc_plus4_valid_o`  out  1 each  redirect qualifiers to PC register
- `busy_o`  out  1  fence.i FSM not IDLE or redirect pending

## Operation
- Stall composition, highest source wins:
  - `mem_stall`: stall[4:0], flush[5].
  - Else `ex_stall`: stall[3:0], flush[4].
  - Else `if_stall`: stall[1:0], flush[2].
- Request acceptance:
  - Branch accepted only when stall_valid_o[3]=0.
  - Trap and fence.i accepted only when `mem_stall_req_i`=0.
  - Priority: trap > fence.i > branch. A same-cycle lower-priority request is dropped.
- Accepted branch: OR flush[2:1] into flush_valid_o. Accepted trap or fence.i: OR flush[4:1]. Flush overrides stall on the same bit (that stage's stall bit is forced to 0).
- Redirect delivery:
  - If stall_valid_o[0]=0 in the accept cycle, drive the redirect combinationally in that cycle (zero latency).
  - Otherwise load pending register {pend_valid, pend_kind, pend_pc}. Deliver it in the first cycle with stall_valid_o[0]=0, asserting flush[1] that cycle to kill the stale fetch.
  - A trap accepted while a branch is pending overwrites the pending entry.
- Qualifier encoding:
  - Branch: branch_pc_valid_o=1.
  - Trap: clint_pc_valid_o=1.
  - Fence.i: clint_pc_valid_o=1 and clint_pc_plus4_valid_o=1, with redirect_pc_o=fencei PC.
  - At most one qualifier set per cycle. Qualifiers are 0 whenever stall_valid_o[0]=1.
- Fence.i FSM, states IDLE, FLUSH, REDIR:
  - IDLE→FLUSH on accepted fence.i. Latch fencei_pc_i and set icache_flush_req_o=1.
  - FLUSH: stall[1:0] forced to 1. On `icache_flush_done_i`, drop the request and go to REDIR.
  - REDIR: present the fence.i redirect when stall_valid_o[0]=0, then return to IDLE. Otherwise hold.
  - While not IDLE, branch/trap/fence.i requests are ignored.
- When no stall, request or pending redirect is present, all outputs are 0.

## Timing
- Reset (rst=0, async): FSM=IDLE, pend_valid=0, icache_flush_req_o=0, busy_o=0. stall_valid_o, flush_valid_o, qualifiers and redirect_pc_o all 0.
- stall_valid_o and flush_valid_o are combinational from current inputs and state; no added latency.
- Pending redirect takes effect on the PC register at the first rising edge where stall_valid_o[0]=0.
- icache_flush_req_o rises on the edge after fence.i is accepted and falls on the edge after the done pulse.
- Fence.i minimum end-to-end: accept → FLUSH (≥1 cycle) → REDIR (1 cycle) → IDLE.
- Reset asserted mid-sequence aborts immediately. No request or pending redirect survives it.
- A done pulse arriving outside FLUSH is ignored.

## Test plan
- ex_stall=1 only → stall=6'b001111, flush=6'b010000. Raising mem_stall as well → stall=6'b011111, flush=6'b100000.
- Branch to 0x8000_0100 with no stall → same cycle branch_pc_valid_o=1, redirect_pc_o=0x8000_0100, flush=6'b000110.
- Branch while if_stall=1 for 3 cycles:
  - Accept cycle: flush=6'b000110, stall=6'b000001 (bit1 stall overridden by flush); no qualifier.
  - Next 2 cycles: stall=6'b000011, no qualifier, busy_o=1.
  - Cycle when if_stall drops: redirect delivered with flush[1]=1, busy_o→0.
- Trap to 0x8000_0200 and branch in the same cycle → only clint_pc_valid_o=1, redirect_pc_o=0x8000_0200, flush=6'b011110.
- fence.i at PC 0x8000_0040 with done arriving 5 cycles later:
  - icache_flush_req_o high for 5 cycles, stall[1:0]=2'b11 throughout.
  - Then one cycle with both clint qualifiers set and redirect_pc_o=0x8000_0040.
  - A branch injected during FLUSH is ignored.
- rst=0 asserted during FLUSH → all outputs 0 asynchronously. After release, FSM is IDLE and a stale done pulse has no effect.

Source files
------------

// File: rtl/ysyx_041514_pipe_ctrl.sv
// Central pipeline controller: merges stage stalls, arbitrates PC redirects
// (branch / trap / fence.i) and sequences the fence.i icache-flush handshake.
module ysyx_041514_pipe_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_stall_req_i,
  input  logic            ex_stall_req_i,
  input  logic            mem_stall_req_i,
  input  logic            branch_req_i,
  input  logic [XLEN-1:0] branch_pc_i,
  input  logic            trap_req_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            fencei_req_i,
  input  logic [XLEN-1:0] fencei_pc_i,
  input  logic            icache_flush_done_i,
  output logic            icache_flush_req_o,
  output logic [5:0]      stall_valid_o,
  output logic [5:0]      flush_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            branch_pc_valid_o,
  output logic            clint_pc_valid_o,
  output logic            clint_pc_plus4_valid_o,
  output logic            busy_o
);

  localparam int unsigned NSTAGE = 6;
  localparam logic [NSTAGE-1:0] KILL_FRONT = 6'b000110;
  localparam logic [NSTAGE-1:0] KILL_UPTO_EX = 6'b011110;

  typedef enum logic [1:0] {
    FI_IDLE,
    FI_FLUSH,
    FI_REDIR
  } fi_state_t;

  typedef enum logic {
    PEND_BRANCH,
    PEND_TRAP
  } pend_kind_t;

  fi_state_t         state;
  logic              flush_req;
  logic [XLEN-1:0]   fencei_pc;
  logic              pend_valid;
  pend_kind_t        pend_kind;
  logic [XLEN-1:0]   pend_pc;

  logic [NSTAGE-1:0] base_stall;
  logic [NSTAGE-1:0] base_flush;
  logic [NSTAGE-1:0] kill;
  logic              idle;
  logic              pc_stall;
  logic              trap_acc;
  logic              fencei_acc;
  logic              branch_acc;
  logic              pend_deliver;

  // Highest stalled stage freezes everything upstream and bubbles the next one.
  always_comb begin : stall_compose
    base_stall = '0;
    base_flush = '0;
    if (mem_stall_req_i) begin
      base_stall = 6'b011111;
      base_flush = 6'b100000;
    end else if (ex_stall_req_i) begin
      base_stall = 6'b001111;
      base_flush = 6'b010000;
    end else if (if_stall_req_i) begin
      base_stall = 6'b000011;
      base_flush = 6'b000100;
    end
    if (state == FI_FLUSH) begin
      base_stall[1:0] = 2'b11;
    end
  end

  assign idle     = (state == FI_IDLE);
  assign pc_stall = base_stall[0];

  assign trap_acc     = idle & trap_req_i & ~mem_stall_req_i;
  assign fencei_acc   = idle & fencei_req_i & ~mem_stall_req_i & ~trap_req_i;
  assign branch_acc   = idle & branch_req_i & ~base_stall[3] & ~trap_acc & ~fencei_acc;
  // A newly accepted request supersedes whatever is still pending.
  assign pend_deliver = pend_valid & ~pc_stall & ~trap_acc & ~branch_acc & ~fencei_acc;

  always_comb begin : redirect_out
    kill                   = '0;
    redirect_pc_o          = '0;
    branch_pc_valid_o      = 1'b0;
    clint_pc_valid_o       = 1'b0;
    clint_pc_plus4_valid_o = 1'b0;
    if (branch_acc) begin
      kill = KILL_FRONT;
    end
    if (trap_acc || fencei_acc) begin
      kill = KILL_UPTO_EX;
    end
    if (pend_deliver) begin
      kill[1] = 1'b1;
    end
    if (!pc_stall) begin
      if (trap_acc) begin
        clint_pc_valid_o = 1'b1;
        redirect_pc_o    = trap_pc_i;
      end else if (branch_acc) begin
        branch_pc_valid_o = 1'b1;
        redirect_pc_o     = branch_pc_i;
      end else if (state == FI_REDIR) begin
        clint_pc_valid_o       = 1'b1;
        clint_pc_plus4_valid_o = 1'b1;
        redirect_pc_o          = fencei_pc;
      end else if (pend_deliver) begin
        if (pend_kind == PEND_TRAP) begin
          clint_pc_valid_o = 1'b1;
        end else begin
          branch_pc_valid_o = 1'b1;
        end
        redirect_pc_o = pend_pc;
      end
    end
    flush_valid_o = base_flush | kill;
    stall_valid_o = base_stall & ~flush_valid_o;
    // Reset silences the combinational buses immediately.
    if (!rst) begin
      flush_valid_o          = '0;
      stall_valid_o          = '0;
      redirect_pc_o          = '0;
      branch_pc_valid_o      = 1'b0;
      clint_pc_valid_o       = 1'b0;
      clint_pc_plus4_valid_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FI_IDLE;
      flush_req  <= 1'b0;
      fencei_pc  <= '0;
      pend_valid <= 1'b0;
      pend_kind  <= PEND_BRANCH;
      pend_pc    <= '0;
    end else begin
      unique case (state)
        FI_IDLE: begin
          if (fencei_acc) begin
            state     <= FI_FLUSH;
            flush_req <= 1'b1;
            fencei_pc <= fencei_pc_i;
          end
        end
        FI_FLUSH: begin
          if (icache_flush_done_i) begin
            state     <= FI_REDIR;
            flush_req <= 1'b0;
          end
        end
        FI_REDIR: begin
          if (!pc_stall) begin
            state <= FI_IDLE;
          end
        end
        default: state <= FI_IDLE;
      endcase

      // Redirects that cannot reach the PC this cycle are parked here.
      if (trap_acc || branch_acc) begin
        pend_valid <= pc_stall;
        pend_kind  <= trap_acc ? PEND_TRAP : PEND_BRANCH;
        pend_pc    <= trap_acc ? trap_pc_i : branch_pc_i;
      end else if (fencei_acc || pend_deliver) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign icache_flush_req_o = flush_req;
  assign busy_o             = ~idle | pend_valid;

endmodule

// File: tb/tb_ysyx_041514_pipe_ctrl.sv
// Bench for ysyx_041514_pipe_ctrl: directed vector table, multi-cycle
// sequences and a randomized run against a behavioural reference model.
module tb_ysyx_041514_pipe_ctrl;

  localparam logic [63:0] BPC = 64'h0000_0000_8000_0100;
  localparam logic [63:0] TPC = 64'h0000_0000_8000_0200;
  localparam logic [63:0] FPC = 64'h0000_0000_8000_0040;

  typedef struct packed {
    logic ifs, exs, mems, br, tr, fe, done;
    logic [63:0] bpc, tpc, fpc;
  } vin_t;

  typedef struct packed {
    logic [5:0]  stall, flush;
    logic        bq, cq, c4q, req, busy;
    logic [63:0] pc;
  } vout_t;

  typedef struct packed {
    vin_t  i;
    vout_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall, ex_stall, mem_stall, branch_req, trap_req, fencei_req, done;
  logic [63:0] branch_pc, trap_pc, fencei_pc;
  logic        flush_req, bq, cq, c4q, busy;
  logic [5:0]  stall_valid, flush_valid;
  logic [63:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  // Reference-model state
  int          m_phase;
  logic        m_req, m_pend, m_ptrap;
  logic [63:0] m_fpc, m_ppc;

  always #5 clk = ~clk;

  ysyx_041514_pipe_ctrl #(.XLEN(64)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .if_stall_req_i         (if_stall),
    .ex_stall_req_i         (ex_stall),
    .mem_stall_req_i        (mem_stall),
    .branch_req_i           (branch_req),
    .branch_pc_i            (branch_pc),
    .trap_req_i             (trap_req),
    .trap_pc_i              (trap_pc),
    .fencei_req_i           (fencei_req),
    .fencei_pc_i            (fencei_pc),
    .icache_flush_done_i    (done),
    .icache_flush_req_o     (flush_req),
    .stall_valid_o          (stall_valid),
    .flush_valid_o          (flush_valid),
    .redirect_pc_o          (redirect_pc),
    .branch_pc_valid_o      (bq),
    .clint_pc_valid_o       (cq),
    .clint_pc_plus4_valid_o (c4q),
    .busy_o                 (busy)
  );

  function automatic vec_t mkv(logic [6:0] in_bits, logic [5:0] st, logic [5:0] fl,
                               logic [2:0] q, logic [63:0] pc, logic req, logic bsy);
    vec_t r;
    r = '0;
    {r.i.ifs, r.i.exs, r.i.mems, r.i.br, r.i.tr, r.i.fe, r.i.done} = in_bits;
    r.i.bpc = BPC;
    r.i.tpc = TPC;
    r.i.fpc = FPC;
    r.o.stall = st;
    r.o.flush = fl;
    {r.o.bq, r.o.cq, r.o.c4q} = q;
    r.o.pc   = pc;
    r.o.req  = req;
    r.o.busy = bsy;
    return r;
  endfunction

  task automatic drive(input vin_t v);
    if_stall   = v.ifs;
    ex_stall   = v.exs;
    mem_stall  = v.mems;
    branch_req = v.br;
    trap_req   = v.tr;
    fencei_req = v.fe;
    done       = v.done;
    branch_pc  = v.bpc;
    trap_pc    = v.tpc;
    fencei_pc  = v.fpc;
  endtask

  task automatic cmp(input string tag, input string what, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s got=%h exp=%h", tag, what, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input vout_t e);
    cmp(tag, "stall", 64'(stall_valid), 64'(e.stall));
    cmp(tag, "flush", 64'(flush_valid), 64'(e.flush));
    cmp(tag, "branch_q", 64'(bq), 64'(e.bq));
    cmp(tag, "clint_q", 64'(cq), 64'(e.cq));
    cmp(tag, "clint4_q", 64'(c4q), 64'(e.c4q));
    cmp(tag, "icache_req", 64'(flush_req), 64'(e.req));
    cmp(tag, "busy", 64'(busy), 64'(e.busy));
    cmp(tag, "redirect_pc", redirect_pc, e.pc);
  endtask

  // Apply inputs just after the falling edge, check before the next rising edge.
  task automatic step(input string tag, input vec_t v);
    drive(v.i);
    #1;
    check_out(tag, v.o);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive('0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_req   = 1'b0;
    m_pend  = 1'b0;
    m_ptrap = 1'b0;
    m_fpc   = '0;
    m_ppc   = '0;
  endtask

  // Behavioural model: phase 0 idle, 1 waiting on icache, 2 fence.i redirect due.
  // win: 0 none, 1 branch, 2 fence.i, 3 trap.
  task automatic model_step(input vin_t v, output vout_t e);
    int         depth;
    int         win;
    logic [5:0] kill;
    e = '0;
    depth = v.mems ? 5 : v.exs ? 4 : v.ifs ? 2 : 0;
    if (depth > 0) begin
      e.stall = 6'((1 << depth) - 1);
      e.flush = 6'(1 << depth);
    end
    if (m_phase == 1) e.stall[1:0] = 2'b11;
    e.req  = m_req;
    e.busy = (m_phase != 0) || m_pend;
    win = 0;
    if (m_phase == 0 && !v.mems) begin
      if (v.tr) win = 3;
      else if (v.fe) win = 2;
    end
    if (m_phase == 0 && win == 0 && v.br && !e.stall[3]) win = 1;
    kill = (win == 1) ? 6'b000110 : (win >= 2) ? 6'b011110 : 6'b000000;
    if (!e.stall[0]) begin
      if (win == 3) begin
        e.cq = 1'b1;
        e.pc = v.tpc;
      end else if (win == 1) begin
        e.bq = 1'b1;
        e.pc = v.bpc;
      end else if (win == 0 && m_phase == 2) begin
        e.cq = 1'b1;
        e.c4q = 1'b1;
        e.pc = m_fpc;
        m_phase = 0;
      end else if (win == 0 && m_pend) begin
        kill[1] = 1'b1;
        if (m_ptrap) e.cq = 1'b1;
        else e.bq = 1'b1;
        e.pc = m_ppc;
        m_pend = 1'b0;
      end
    end
    e.flush = e.flush | kill;
    e.stall = e.stall & ~e.flush;
    if (win == 1 || win == 3) begin
      m_pend  = e.stall[0];
      m_ptrap = (win == 3);
      m_ppc   = (win == 3) ? v.tpc : v.bpc;
    end else if (win == 2) begin
      m_pend  = 1'b0;
      m_phase = 1;
      m_req   = 1'b1;
      m_fpc   = v.fpc;
    end else if (m_phase == 1 && v.done) begin
      m_phase = 2;
      m_req   = 1'b0;
    end
  endtask

  vec_t  tbl[15];
  vin_t  rv;
  vout_t ev;
  vout_t zero_out;

  initial begin
    zero_out = '0;
    // if ex mem br tr fe done
    tbl[0]  = mkv(7'b0000000, 6'b000000, 6'b000000, 3'b000, '0, 1'b0, 1'b0);
    tbl[1]  = mkv(7'b0100000, 6'b001111, 6'b010000, 3'b000, '0, 1'b0, 1'b0);
    tbl[2]  = mkv(7'b0110000, 6'b011111, 6'b100000, 3'b000, '0, 1'b0, 1'b0);
    tbl[3]  = mkv(7'b1000000, 6'b000011, 6'b000100, 3'b000, '0, 1'b0, 1'b0);
    tbl[4]  = mkv(7'b0001000, 6'b000000, 6'b000110, 3'b100, BPC, 1'b0, 1'b0);
    tbl[5]  = mkv(7'b0001100, 6'b000000, 6'b011110, 3'b010, TPC, 1'b0, 1'b0);
    tbl[6]  = mkv(7'b0101000, 6'b001111, 6'b010000, 3'b000, '0, 1'b0, 1'b0);
    tbl[7]  = mkv(7'b0010100, 6'b011111, 6'b100000, 3'b000, '0, 1'b0, 1'b0);
    tbl[8]  = mkv(7'b0000010, 6'b000000, 6'b011110, 3'b000, '0, 1'b0, 1'b0);
    tbl[9]  = mkv(7'b0000110, 6'b000000, 6'b011110, 3'b010, TPC, 1'b0, 1'b0);
    tbl[10] = mkv(7'b1001000, 6'b000001, 6'b000110, 3'b000, '0, 1'b0, 1'b0);
    tbl[11] = mkv(7'b0100100, 6'b000001, 6'b011110, 3'b000, '0, 1'b0, 1'b0);
    tbl[12] = mkv(7'b0101010, 6'b000001, 6'b011110, 3'b000, '0, 1'b0, 1'b0);
    tbl[13] = mkv(7'b0000001, 6'b000000, 6'b000000, 3'b000, '0, 1'b0, 1'b0);
    tbl[14] = mkv(7'b1110111, 6'b011111, 6'b100000, 3'b000, '0, 1'b0, 1'b0);

    drive('0);
    rst = 1'b0;
    #1;
    check_out("reset", zero_out);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      do_reset();
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // Branch parked behind a 3-cycle icache stall
    do_reset();
    step("brpend0", mkv(7'b1001000, 6'b000001, 6'b000110, 3'b000, '0, 1'b0, 1'b0));
    step("brpend1", mkv(7'b1000000, 6'b000011, 6'b000100, 3'b000, '0, 1'b0, 1'b1));
    step("brpend2", mkv(7'b1000000, 6'b000011, 6'b000100, 3'b000, '0, 1'b0, 1'b1));
    step("brpend3", mkv(7'b0000000, 6'b000000, 6'b000010, 3'b100, BPC, 1'b0, 1'b1));
    step("brpend4", mkv(7'b0000000, 6'b000000, 6'b000000, 3'b000, '0, 1'b0, 1'b0));

    // fence.i with done five cycles later and a branch during FLUSH
    step("fence0", mkv(7'b0000010, 6'b000000, 6'b011110, 3'b000, '0, 1'b0, 1'b0));
    step("fence1", mkv(7'b0000000, 6'b000011, 6'b000000, 3'b000, '0, 1'b1, 1'b1));
    step("fence2", mkv(7'b0001000, 6'b000011, 6'b000000, 3'b000, '0, 1'b1, 1'b1));
    step("fence3", mkv(7'b0000000, 6'b000011, 6'b000000, 3'b000, '0, 1'b1, 1'b1));
    step("fence4", mkv(7'b0000000, 6'b000011, 6'b000000, 3'b000, '0, 1'b1, 1'b1));
    step("fence5", mkv(7'b0000001, 6'b000011, 6'b000000, 3'b000, '0, 1'b1, 1'b1));
    step("fence6", mkv(7'b0000000, 6'b000000, 6'b000000, 3'b011, FPC, 1'b0, 1'b1));
    step("fence7", mkv(7'b0000000, 6'b000000, 6'b000000, 3'b000, '0, 1'b0, 1'b0));

    // Trap overwrites a pending branch
    step("ovr0", mkv(7'b1001000, 6'b000001, 6'b000110, 3'b000, '0, 1'b0, 1'b0));
    step("ovr1", mkv(7'b1000100, 6'b000001, 6'b011110, 3'b000, '0, 1'b0, 1'b1));
    step("ovr2", mkv(7'b0000000, 6'b000000, 6'b000010, 3'b010, TPC, 1'b0, 1'b1));
    step("ovr3", mkv(7'b0000000, 6'b000000, 6'b000000, 3'b000, '0, 1'b0, 1'b0));

    // Reset in the middle of FLUSH, then a stale done pulse
    step("rstmid0", mkv(7'b0000010, 6'b000000, 6'b011110, 3'b000, '0, 1'b0, 1'b0));
    step("rstmid1", mkv(7'b0000000, 6'b000011, 6'b000000, 3'b000, '0, 1'b1, 1'b1));
    drive(mkv(7'b1000000, '0, '0, '0, '0, 1'b0, 1'b0).i);
    #2;
    rst = 1'b0;
    #1;
    check_out("rst_async", zero_out);
    @(negedge clk);
    rst = 1'b1;
    step("rstmid2", mkv(7'b0000001, 6'b000000, 6'b000000, 3'b000, '0, 1'b0, 1'b0));
    step("rstmid3", mkv(7'b0000000, 6'b000000, 6'b000000, 3'b000, '0, 1'b0, 1'b0));

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      rv.ifs  = ($urandom_range(0, 99) < 30);
      rv.exs  = ($urandom_range(0, 99) < 20);
      rv.mems = ($urandom_range(0, 99) < 15);
      rv.br   = ($urandom_range(0, 99) < 25);
      rv.tr   = ($urandom_range(0, 99) < 8);
      rv.fe   = ($urandom_range(0, 99) < 6);
      rv.done = ($urandom_range(0, 99) < 15);
      rv.bpc  = {$urandom, $urandom};
      rv.tpc  = {$urandom, $urandom};
      rv.fpc  = {$urandom, $urandom};
      drive(rv);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        #1;
        check_out($sformatf("rnd_rst%0d", n), zero_out);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
      end else begin
        #1;
        model_step(rv, ev);
        check_out($sformatf("rnd%0d", n), ev);
        @(negedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
